// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx_if
//  Purpose  : Bundles the FIFO read port (fifo_empty / fifo_dout / fifo_rd_en)
//             and the serial-side outputs (tx / busy / tx_done) of the
//             fifo_uart_tx block.
//  Modports : master - the transmitter (pops the FIFO, drives the line)
//             slave  - the FIFO / line side (supplies data, observes line)
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Drains a synchronous FIFO one word at a time and serialises
//             each word as a frame: start bit (0), DATA_WIDTH data bits LSB
//             first, stop bit (1). Words are sent back-to-back while the FIFO
//             holds data.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset
//             bus.fifo_empty - FIFO empty flag (in)
//             bus.fifo_dout  - FIFO read data, valid the cycle after rd_en (in)
//             bus.fifo_rd_en - one-cycle pop strobe per word (out)
//             bus.tx         - registered serial line, idles high (out)
//             bus.busy       - high whenever not idle (out)
//             bus.tx_done    - pulse on the final cycle of each stop bit (out)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fifo_uart_tx_if.master bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH   > 1) ? $clog2(DATA_WIDTH)   : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_POP   = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_START = 3'd3;
    localparam logic [2:0] C_DATA  = 3'd4;
    localparam logic [2:0] C_STOP  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q,    tx_d;
    logic                  w_bit_end;
    logic                  w_rd_en;
    logic                  w_busy;
    logic                  w_tx_done;

    // Last clock of the current serial bit.
    assign w_bit_end = (cnt_q == C_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. fifo_empty is only looked at in IDLE and on the
    // last STOP cycle, so a pop is only ever issued against a non-empty FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (!bus.fifo_empty) state_d = C_POP;
            C_POP:   state_d = C_LOAD;
            C_LOAD:  state_d = C_START;
            C_START: if (w_bit_end) state_d = C_DATA;
            C_DATA:  if (w_bit_end && (idx_q == C_IDX_LAST)) state_d = C_STOP;
            C_STOP:  if (w_bit_end) state_d = bus.fifo_empty ? C_IDLE : C_POP;
            default: state_d = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en   = 1'b0;
        w_busy    = 1'b1;
        w_tx_done = 1'b0;
        case (state_q)
            C_IDLE:  w_busy    = 1'b0;
            C_POP:   w_rd_en   = 1'b1;
            C_STOP:  w_tx_done = w_bit_end;
            default: ;
        endcase
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.busy       = w_busy;
    assign bus.tx_done    = w_tx_done;
    assign bus.tx         = tx_q;

    // ------------------------------------------------------------------
    // Datapath next-value logic: baud counter, bit index, shift register
    // and the line level.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        // The counter restarts on every state change and otherwise wraps on
        // each bit boundary; it only runs while a bit is on the line.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == C_START) || (state_q == C_DATA) || (state_q == C_STOP)) begin
            cnt_d = w_bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            C_LOAD: begin
                shift_d = bus.fifo_dout;
                idx_d   = '0;
            end
            C_DATA: begin
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    // Saturate so the index never runs past the last bit.
                    if (idx_q != C_IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // tx is registered, so it is computed from the state being entered:
        // the line changes on the same edge the state does.
        case (state_d)
            C_START: tx_d = 1'b0;
            C_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire
